// File: rtl/clock_time_setter.sv
// Front-panel hh:mm:ss BCD time entry: debounced mode/up/down buttons, field edit, one-cycle load.
// Optional CLOCK_SETTER_TIMEOUT_EN abandons an edit after TIMEOUT_CYCLES without a press.
module clock_time_setter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLINK_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [23:0] cur_time,
    output logic [23:0] set_time,
    output logic        load,
    output logic        editing,
    output logic [1:0]  field,
    output logic        blink
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        EDIT_H,
        EDIT_M,
        EDIT_S,
        COMMIT
    } state_t;

    state_t state, state_next;

    // Button index 0 = mode, 1 = up, 2 = down
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb;
    logic [2:0]      deb_q;
    logic [2:0]      pulse;
    logic [DB_W-1:0] db_cnt [3];

    logic mode_p;
    logic up_p;
    logic down_p;
    logic inc_req;
    logic dec_req;
    logic state_chg;
    logic timeout;

    logic [BL_W-1:0] blink_cnt;

    assign raw = {btn_down, btn_up, btn_mode};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pulse  = deb & ~deb_q;
    assign mode_p = pulse[0];
    assign up_p   = pulse[1];
    assign down_p = pulse[2];

    // Mode beats up/down; up together with down cancels out
    assign inc_req = up_p & ~down_p & ~mode_p;
    assign dec_req = down_p & ~up_p & ~mode_p;

    // BCD step of one two-digit field; an out-of-range value is forced to 00
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic is_hours,
                                            input logic up);
        logic [3:0] t;
        logic [3:0] u;
        logic [3:0] t_max;
        logic [3:0] u_max;
        logic       valid;
        logic [7:0] r;
        t     = v[7:4];
        u     = v[3:0];
        t_max = is_hours ? 4'd2 : 4'd5;
        u_max = is_hours ? 4'd3 : 4'd9;
        valid = (u <= 4'd9) && ((t < t_max) || ((t == t_max) && (u <= u_max)));
        if (!valid) begin
            r = 8'h00;
        end else if (up) begin
            if ((t == t_max) && (u == u_max)) r = 8'h00;
            else if (u == 4'd9)               r = {t + 4'd1, 4'd0};
            else                              r = {t, u + 4'd1};
        end else begin
            if (v == 8'h00)      r = {t_max, u_max};
            else if (u == 4'd0)  r = {t - 4'd1, 4'd9};
            else                 r = {t, u - 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (mode_p) state_next = EDIT_H;
            EDIT_H: if (mode_p) state_next = EDIT_M; else if (timeout) state_next = IDLE;
            EDIT_M: if (mode_p) state_next = EDIT_S; else if (timeout) state_next = IDLE;
            EDIT_S: if (mode_p) state_next = COMMIT; else if (timeout) state_next = IDLE;
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        editing = 1'b0;
        field   = 2'd0;
        case (state)
            EDIT_H: begin editing = 1'b1; field = 2'd1; end
            EDIT_M: begin editing = 1'b1; field = 2'd2; end
            EDIT_S: begin editing = 1'b1; field = 2'd3; end
            default: begin editing = 1'b0; field = 2'd0; end
        endcase
    end

    assign state_chg = (state_next != state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load <= 1'b0;
        end else begin
            load <= (state_next == COMMIT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_time <= '0;
        end else if ((state == IDLE) && mode_p) begin
            set_time <= cur_time;
        end else if (inc_req || dec_req) begin
            case (state)
                EDIT_H:  set_time[23:16] <= bcd_step(set_time[23:16], 1'b1, inc_req);
                EDIT_M:  set_time[15:8]  <= bcd_step(set_time[15:8],  1'b0, inc_req);
                EDIT_S:  set_time[7:0]   <= bcd_step(set_time[7:0],   1'b0, inc_req);
                default: set_time        <= set_time;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (!editing || state_chg || up_p || down_p) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

`ifdef CLOCK_SETTER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (!editing || state_chg || (|pulse)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = editing && (to_cnt == TO_LAST) && !(|pulse);
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_setter.sv
// Scoreboard bench for clock_time_setter: stimulus queues expected output events,
// a negedge monitor pops one entry each time {set_time, load, editing, field} changes.
module tb_clock_time_setter;

    logic        clk;
    logic        reset;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic [23:0] cur_time;
    logic [23:0] set_time;
    logic        load;
    logic        editing;
    logic [1:0]  field;
    logic        blink;

    typedef struct packed {
        logic [23:0] t;
        logic        ld;
        logic        ed;
        logic [1:0]  f;
    } obs_t;

    obs_t exp_q [$];
    obs_t prev_obs;
    obs_t cur_obs;
    obs_t exp_obs;
    logic mon_en;
    int   checks;
    int   failures;

    clock_time_setter #(
        .DEBOUNCE_CYCLES(16),
        .BLINK_CYCLES(8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .cur_time(cur_time),
        .set_time(set_time),
        .load(load),
        .editing(editing),
        .field(field),
        .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            cur_obs = '{t: set_time, ld: load, ed: editing, f: field};
            if (cur_obs !== prev_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got t=%h ld=%b ed=%b f=%0d, required no change",
                             cur_obs.t, cur_obs.ld, cur_obs.ed, cur_obs.f);
                end else begin
                    exp_obs = exp_q.pop_front();
                    if (cur_obs !== exp_obs) begin
                        failures++;
                        $display("FAIL event got t=%h ld=%b ed=%b f=%0d, required t=%h ld=%b ed=%b f=%0d",
                                 cur_obs.t, cur_obs.ld, cur_obs.ed, cur_obs.f,
                                 exp_obs.t, exp_obs.ld, exp_obs.ed, exp_obs.f);
                    end
                end
                prev_obs = cur_obs;
            end
        end
    end

    task automatic expect_ev(input logic [23:0] t, input logic ld, input logic ed,
                             input logic [1:0] f);
        obs_t e;
        e = '{t: t, ld: ld, ed: ed, f: f};
        exp_q.push_back(e);
    endtask

    task automatic press(input logic m, input logic u, input logic d, input int hold);
        @(posedge clk);
        #1;
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (24) @(posedge clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic measure_blink();
        int   n;
        logic b0;
        n  = 0;
        @(negedge clk);
        b0 = blink;
        while (blink === b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("blink_toggle_seen", 32'(n < 20), 32'd1);
        for (int k = 0; k < 2; k++) begin
            b0 = blink;
            n  = 0;
            do begin
                @(negedge clk);
                n++;
            end while (blink === b0 && n < 20);
            check_val("blink_half_period", 32'(n), 32'd8);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        mon_en   = 1'b0;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cur_time = 24'h235958;
        repeat (4) @(posedge clk);
        #1;
        check_val("reset_set_time", 32'(set_time), 32'h0);
        check_val("reset_flags", 32'({load, editing, field, blink}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        prev_obs = '{t: set_time, ld: load, ed: editing, f: field};
        mon_en   = 1'b1;

        // Up in IDLE is ignored
        press(1'b0, 1'b1, 1'b0, 24);
        expect_ev(24'h235958, 1'b0, 1'b1, 2'd1);
        press(1'b1, 1'b0, 1'b0, 24);
        measure_blink();

        // Short glitch must not produce a pulse
        @(posedge clk);
        #1 btn_up = 1'b1;
        repeat (14) @(posedge clk);
        #1 btn_up = 1'b0;
        repeat (30) @(posedge clk);

        // Long hold yields one increment; hours wrap 23 -> 00 and back
        expect_ev(24'h005958, 1'b0, 1'b1, 2'd1);
        press(1'b0, 1'b1, 1'b0, 100);
        expect_ev(24'h235958, 1'b0, 1'b1, 2'd1);
        press(1'b0, 1'b0, 1'b1, 24);
        expect_ev(24'h225958, 1'b0, 1'b1, 2'd1);
        press(1'b0, 1'b0, 1'b1, 24);

        // mode+up: mode wins; up+down: nothing
        expect_ev(24'h225958, 1'b0, 1'b1, 2'd2);
        press(1'b1, 1'b1, 1'b0, 24);
        press(1'b0, 1'b1, 1'b1, 24);
        expect_ev(24'h225958, 1'b0, 1'b1, 2'd3);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h225959, 1'b0, 1'b1, 2'd3);
        press(1'b0, 1'b1, 1'b0, 24);
        expect_ev(24'h225900, 1'b0, 1'b1, 2'd3);
        press(1'b0, 1'b1, 1'b0, 24);
        expect_ev(24'h225900, 1'b1, 1'b0, 2'd0);
        expect_ev(24'h225900, 1'b0, 1'b0, 2'd0);
        press(1'b1, 1'b0, 1'b0, 24);

        // Full commit from 07:15:30
        cur_time = 24'h071530;
        expect_ev(24'h071530, 1'b0, 1'b1, 2'd1);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h081530, 1'b0, 1'b1, 2'd1);
        press(1'b0, 1'b1, 1'b0, 24);
        expect_ev(24'h081530, 1'b0, 1'b1, 2'd2);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h081530, 1'b0, 1'b1, 2'd3);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h081529, 1'b0, 1'b1, 2'd3);
        press(1'b0, 1'b0, 1'b1, 24);
        expect_ev(24'h081529, 1'b1, 1'b0, 2'd0);
        expect_ev(24'h081529, 1'b0, 1'b0, 2'd0);
        press(1'b1, 1'b0, 1'b0, 24);

        // Hours borrow 10 -> 09, minutes carry 09 -> 10 and back
        cur_time = 24'h100900;
        expect_ev(24'h100900, 1'b0, 1'b1, 2'd1);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h090900, 1'b0, 1'b1, 2'd1);
        press(1'b0, 1'b0, 1'b1, 24);
        expect_ev(24'h090900, 1'b0, 1'b1, 2'd2);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h091000, 1'b0, 1'b1, 2'd2);
        press(1'b0, 1'b1, 1'b0, 24);
        expect_ev(24'h090900, 1'b0, 1'b1, 2'd2);
        press(1'b0, 1'b0, 1'b1, 24);
        expect_ev(24'h090900, 1'b0, 1'b1, 2'd3);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h090900, 1'b1, 1'b0, 2'd0);
        expect_ev(24'h090900, 1'b0, 1'b0, 2'd0);
        press(1'b1, 1'b0, 1'b0, 24);

        // Reset in the middle of an edit
        cur_time = 24'h123456;
        expect_ev(24'h123456, 1'b0, 1'b1, 2'd1);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h123456, 1'b0, 1'b1, 2'd2);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h000000, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("midreset_set_time", 32'(set_time), 32'h0);
        check_val("midreset_flags", 32'({load, editing, field}), 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Out-of-range hours forced to 00; minutes/seconds 00 borrow to 59
        cur_time = 24'h250000;
        expect_ev(24'h250000, 1'b0, 1'b1, 2'd1);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h000000, 1'b0, 1'b1, 2'd1);
        press(1'b0, 1'b1, 1'b0, 24);
        expect_ev(24'h230000, 1'b0, 1'b1, 2'd1);
        press(1'b0, 1'b0, 1'b1, 24);
        expect_ev(24'h230000, 1'b0, 1'b1, 2'd2);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h235900, 1'b0, 1'b1, 2'd2);
        press(1'b0, 1'b0, 1'b1, 24);
        expect_ev(24'h235900, 1'b0, 1'b1, 2'd3);
        press(1'b1, 1'b0, 1'b0, 24);
        expect_ev(24'h235959, 1'b0, 1'b1, 2'd3);
        press(1'b0, 1'b0, 1'b1, 24);
`ifdef CLOCK_SETTER_TIMEOUT_EN
        expect_ev(24'h235959, 1'b0, 1'b0, 2'd0);
        repeat (100) @(posedge clk);
`else
        repeat (100) @(posedge clk);
        expect_ev(24'h235959, 1'b1, 1'b0, 2'd0);
        expect_ev(24'h235959, 1'b0, 1'b0, 2'd0);
        press(1'b1, 1'b0, 1'b0, 24);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
